// File: rtl/uart_reg_bridge_pkg.sv
// Shared protocol constants, register map and FSM encoding for the UART register bridge.
package uart_reg_bridge_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 8;

  localparam logic [ADDR_WIDTH-1:0] CH_MUX_ENABLE = 6'h05;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_NAK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_TX_RESP
  } state_e;

  typedef enum logic {
    OP_KIND_WR,
    OP_KIND_RD
  } op_e;

  // The address byte carries more bits than the map decodes; the extras are ignored.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [7:0] b);
    return b[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// UART byte streams and main_memory register bus, seen from the bridge (master) and its environment (slave).
interface uart_reg_bridge_if;

  logic [7:0]                                 i_rx_data;
  logic                                       i_rx_valid;
  logic [7:0]                                 o_tx_data;
  logic                                       o_tx_valid;
  logic                                       i_tx_ready;
  logic [uart_reg_bridge_pkg::ADDR_WIDTH-1:0] o_addr;
  logic [uart_reg_bridge_pkg::DATA_WIDTH-1:0] o_data;
  logic                                       o_wr;
  logic [uart_reg_bridge_pkg::DATA_WIDTH-1:0] i_rd_data;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_rd_data,
    output o_tx_data, o_tx_valid, o_addr, o_data, o_wr
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_rd_data,
    input  o_tx_data, o_tx_valid, o_addr, o_data, o_wr
  );

endinterface

// File: rtl/uart_bridge_timer.sv
// Partial-frame idle timer; only present when UART_BRIDGE_TIMEOUT_EN is defined.
`ifdef UART_BRIDGE_TIMEOUT_EN
module uart_bridge_timer #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  // Fires on the LIMIT-th consecutive idle cycle spent inside a frame.
  assign o_expire = i_run && !i_clr && (count == W'(LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run || i_clr || o_expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uart_reg_bridge.sv
// UART command decoder: OP_WR/OP_RD byte frames become main_memory bus cycles plus one reply byte.
// Optional partial-frame timeout is enabled with the macro UART_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_reg_bridge_if.master   bus,
  output logic                o_busy,
  output logic                o_err
);

  localparam logic [1:0] RD_LAST = 2'(RD_LATENCY - 1);

  state_e     state;
  op_e        op;
  logic [1:0] rd_cnt;
  logic       tmo_expire;
  logic       in_frame;

  assign in_frame = (state == ST_GET_ADDR) || (state == ST_GET_DATA);

`ifdef UART_BRIDGE_TIMEOUT_EN
  uart_bridge_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (in_frame),
    .i_clr    (bus.i_rx_valid),
    .o_expire (tmo_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) && in_frame;
  assign tmo_expire         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset clears every register, bus-facing addr/data included, so all outputs read 0.
    if (i_rst) begin
      state          <= ST_IDLE;
      op             <= OP_KIND_WR;
      rd_cnt         <= '0;
      bus.o_tx_data  <= '0;
      bus.o_tx_valid <= 1'b0;
      bus.o_addr     <= '0;
      bus.o_data     <= '0;
      bus.o_wr       <= 1'b0;
      o_busy         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      // NOTE: o_err defaults low every cycle, so each assignment below is a one-cycle pulse.
      o_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_rx_valid) begin
            o_busy <= 1'b1;
            if (bus.i_rx_data == OP_WR || bus.i_rx_data == OP_RD) begin
              op    <= (bus.i_rx_data == OP_WR) ? OP_KIND_WR : OP_KIND_RD;
              state <= ST_GET_ADDR;
            end else begin
              o_err          <= 1'b1;
              bus.o_tx_data  <= RSP_NAK;
              bus.o_tx_valid <= 1'b1;
              state          <= ST_TX_RESP;
            end
          end
        end

        ST_GET_ADDR: begin
          if (bus.i_rx_valid) begin
            bus.o_addr <= addr_of(bus.i_rx_data);
            rd_cnt     <= '0;
            state      <= (op == OP_KIND_WR) ? ST_GET_DATA : ST_RD_WAIT;
          end else if (tmo_expire) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_GET_DATA: begin
          if (bus.i_rx_valid) begin
            bus.o_data <= bus.i_rx_data;
            bus.o_wr   <= 1'b1;
            state      <= ST_WRITE;
          end else if (tmo_expire) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          o_err          <= bus.i_rx_valid;
          bus.o_wr       <= 1'b0;
          bus.o_tx_data  <= RSP_ACK;
          bus.o_tx_valid <= 1'b1;
          state          <= ST_TX_RESP;
        end

        ST_RD_WAIT: begin
          o_err <= bus.i_rx_valid;
          if (rd_cnt == RD_LAST) begin
            state <= ST_RD_CAP;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end

        ST_RD_CAP: begin
          o_err          <= bus.i_rx_valid;
          bus.o_tx_data  <= bus.i_rd_data;
          bus.o_tx_valid <= 1'b1;
          state          <= ST_TX_RESP;
        end

        ST_TX_RESP: begin
          o_err <= bus.i_rx_valid;
          if (bus.i_tx_ready) begin
            bus.o_tx_valid <= 1'b0;
            o_busy         <= 1'b0;
            state          <= ST_IDLE;
          end
        end

        default: begin
          bus.o_wr       <= 1'b0;
          bus.o_tx_valid <= 1'b0;
          o_busy         <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: vector table, corner sequences and random frames vs. a reference model.
module tb_uart_reg_bridge;
  import uart_reg_bridge_pkg::*;

  localparam int unsigned RD_LAT = 1;
`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 100000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;
  logic init_mem;

  uart_reg_bridge_if bus();

  uart_reg_bridge #(
    .RD_LATENCY     (RD_LAT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_busy (busy),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  // main_memory stand-in: registered read, one cycle of latency.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (init_mem) begin
      foreach (mem[i]) mem[i] <= 8'h00;
    end else if (bus.o_wr) begin
      mem[bus.o_addr] <= bus.o_data;
    end
    bus.i_rd_data <= mem[bus.o_addr];
  end

  int         wr_cnt  = 0;
  int         err_cnt = 0;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  always @(posedge clk) begin
    if (bus.o_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.o_addr;
      wr_data <= bus.o_data;
    end
    if (err) err_cnt <= err_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register file plus the frame rules, no notion of states or cycles.
  logic [7:0] ref_mem [64];

  task automatic ref_frame(input logic [2:0][7:0] b, output logic [7:0] rsp);
    case (b[0])
      8'h57: begin ref_mem[b[1] % 64] = b[2]; rsp = 8'h4B; end
      8'h52: rsp = ref_mem[b[1] % 64];
      default: rsp = 8'h3F;
    endcase
  endtask

  function automatic logic [2:0][7:0] mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    return {b2, b1, b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  // Sends one frame from a negedge, checks latency, reply, handshake and side effects.
  task automatic run_frame(input logic [2:0][7:0] b, input logic [7:0] exp_rsp, input int stall, input string tag);
    int n, lat, wr0, err0;
    bit is_wr, is_bad, early;
    is_wr  = (b[0] == 8'h57);
    is_bad = !is_wr && (b[0] != 8'h52);
    n      = is_wr ? 3 : (is_bad ? 1 : 2);
    lat    = is_wr ? 1 : (is_bad ? 0 : int'(RD_LAT) + 1);
    wr0    = wr_cnt;
    err0   = err_cnt;
    early  = 1'b0;
    for (int i = 0; i < n; i++) send_byte(b[i]);
    if (is_wr) begin
      check({tag, " wr strobe"}, bus.o_wr, 1);
      check({tag, " wr addr"}, bus.o_addr, b[1] % 64);
      check({tag, " wr data"}, bus.o_data, b[2]);
    end
    if (is_bad) check({tag, " err pulse"}, err, 1);
    for (int c = 0; c < lat; c++) begin
      if (bus.o_tx_valid) early = 1'b1;
      @(negedge clk);
    end
    check({tag, " early tx"}, early, 0);
    check({tag, " tx at latency"}, bus.o_tx_valid, 1);
    for (int c = 0; c < 20 && !bus.o_tx_valid; c++) @(negedge clk);
    if (!bus.o_tx_valid) begin
      check({tag, " tx timeout"}, 0, 1);
      return;
    end
    check({tag, " rsp"}, bus.o_tx_data, exp_rsp);
    check({tag, " busy"}, busy, 1);
    repeat (stall) @(negedge clk);
    check({tag, " rsp held"}, {bus.o_tx_valid, bus.o_tx_data}, {1'b1, exp_rsp});
    bus.i_tx_ready = 1'b1;
    @(negedge clk);
    bus.i_tx_ready = 1'b0;
    check({tag, " tx drop"}, bus.o_tx_valid, 0);
    check({tag, " idle"}, busy, 0);
    check({tag, " wr count"}, wr_cnt - wr0, is_wr ? 1 : 0);
    if (is_wr) check({tag, " mem bus"}, {wr_addr, wr_data}, {6'(b[1] % 64), b[2]});
    check({tag, " err count"}, err_cnt - err0, is_bad ? 1 : 0);
  endtask

  typedef struct {
    logic [2:0][7:0] b;
    logic [7:0]      rsp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rsp;
    logic [2:0][7:0] fb;
    int wr0, err0, unstable, seen;

    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    vecs[0] = '{mk(8'h57, 8'(CH_MUX_ENABLE), 8'h05), 8'h4B};
    vecs[1] = '{mk(8'h52, 8'(CH_MUX_ENABLE), 8'h00), 8'h05};
    vecs[2] = '{mk(8'h41, 8'h00, 8'h00), 8'h3F};
    vecs[3] = '{mk(8'h57, 8'hC5, 8'hA7), 8'h4B};
    vecs[4] = '{mk(8'h52, 8'h45, 8'h00), 8'hA7};
    vecs[5] = '{mk(8'h52, 8'h3F, 8'h00), 8'h00};
    vecs[6] = '{mk(8'h57, 8'h3F, 8'h5A), 8'h4B};
    vecs[7] = '{mk(8'h52, 8'hFF, 8'h00), 8'h5A};

    rst            = 1'b1;
    init_mem       = 1'b1;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {bus.o_tx_valid, bus.o_wr, busy, err, bus.o_tx_data, bus.o_addr, bus.o_data},
          '0);
    rst      = 1'b0;
    init_mem = 1'b0;
    @(negedge clk);

    // tx_ready while nothing is pending has no effect.
    bus.i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_tx_ready = 1'b0;
    check("idle ready ignored", {bus.o_tx_valid, busy}, 0);

    for (int i = 0; i < 8; i++) begin
      ref_frame(vecs[i].b, rsp);
      run_frame(vecs[i].b, vecs[i].rsp, i % 3, $sformatf("vec%0d", i));
    end

    // Reply stalled for 20 cycles, with a stray byte arriving mid-stall.
    err0 = err_cnt;
    send_byte(8'h52);
    send_byte(8'(CH_MUX_ENABLE));
    for (int c = 0; c < 20 && !bus.o_tx_valid; c++) @(negedge clk);
    check("stall tx valid", bus.o_tx_valid, 1);
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        send_byte(8'h57);
        check("stall stray err", err, 1);
      end else begin
        @(negedge clk);
      end
      if (!bus.o_tx_valid || bus.o_tx_data != 8'hA7) unstable++;
    end
    check("stall held stable", unstable, 0);
    bus.i_tx_ready = 1'b1;
    @(negedge clk);
    bus.i_tx_ready = 1'b0;
    check("stall err count", err_cnt - err0, 1);
    fb = mk(8'h52, 8'h05, 8'h00);
    ref_frame(fb, rsp);
    run_frame(fb, rsp, 0, "after stray");

    // Reset in the middle of a write frame.
    wr0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("midframe reset", {bus.o_tx_valid, bus.o_wr, busy, err, bus.o_tx_data, bus.o_addr, bus.o_data},
          '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe no wr", wr_cnt - wr0, 0);
    fb = mk(8'h57, 8'h22, 8'h99);
    ref_frame(fb, rsp);
    run_frame(fb, rsp, 1, "post reset wr");
    fb = mk(8'h52, 8'h22, 8'h00);
    ref_frame(fb, rsp);
    run_frame(fb, rsp, 0, "post reset rd");

`ifdef UART_BRIDGE_TIMEOUT_EN
    wr0  = wr_cnt;
    seen = 0;
    send_byte(8'h57);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (err) begin
        seen = c;
        break;
      end
    end
    check("timeout cycles", seen, TMO);
    check("timeout idle", {busy, bus.o_tx_valid}, 0);
    check("timeout no wr", wr_cnt - wr0, 0);
    fb = mk(8'h52, 8'h22, 8'h00);
    ref_frame(fb, rsp);
    run_frame(fb, rsp, 0, "after timeout");
`else
    seen = 0;
    check("no timeout marker", seen, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 2))
        0: op = 8'h57;
        1: op = 8'h52;
        default: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
        end
      endcase
      fb = mk(op, 8'($urandom), 8'($urandom));
      ref_frame(fb, rsp);
      run_frame(fb, rsp, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
